// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared pipeline widths, ALU opcodes, control bundle and bubble constant.
package id_ex_stage_pkg;

    localparam int DW = 16;
    localparam int AW = 4;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic       valid;
        logic       reg_wr;
        logic       mem_read;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_STALL,
        ACT_FLUSH,
        ACT_HOLD
    } act_e;

    // An invalid decode slot must never cause a side effect downstream.
    function automatic ctrl_t gate_ctrl(input ctrl_t c);
        return c.valid ? c : CTRL_BUBBLE;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: load-use detection and the hold > flush > load_use > normal edge action.
module hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int AW = id_ex_stage_pkg::AW
) (
    input  logic          hold_i,
    input  logic          flush_i,
    input  logic          ex_valid_i,
    input  logic          ex_mem_read_i,
    input  logic [AW-1:0] ex_rt_i,
    input  logic          id_valid_i,
    input  logic [AW-1:0] id_rs_i,
    input  logic [AW-1:0] id_rt_i,
    output logic          load_use_o,
    output logic          pc_write_o,
    output logic          if_id_write_o,
    output act_e          act_o
);

    always_comb begin
        load_use_o    = ex_valid_i & ex_mem_read_i & (ex_rt_i != AW'(REG_ZERO)) & id_valid_i &
                        ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
        act_o         = hold_i ? ACT_HOLD : flush_i ? ACT_FLUSH : load_use_o ? ACT_STALL : ACT_LOAD;
        pc_write_o    = (act_o == ACT_LOAD) | (act_o == ACT_FLUSH);
        if_id_write_o = pc_write_o;
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and saturating
// stall/flush event counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = id_ex_stage_pkg::DW,
    parameter int AW = id_ex_stage_pkg::AW,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          flush,
    input  logic          if_idValid,
    input  logic [AW-1:0] if_idRs,
    input  logic [AW-1:0] if_idRt,
    input  logic [AW-1:0] if_idRd,
    input  logic          if_idRegWr,
    input  logic          if_idMemRead,
    input  logic          if_idMemWr,
    input  logic          if_idMemToReg,
    input  logic          if_idAluSrc,
    input  logic [3:0]    if_idAluOp,
    input  logic [DW-1:0] if_idRdA,
    input  logic [DW-1:0] if_idRdB,
    input  logic [DW-1:0] if_idImm,
    output logic          id_exValid,
    output logic [AW-1:0] id_exRs,
    output logic [AW-1:0] id_exRt,
    output logic [AW-1:0] id_exRd,
    output logic          id_exRegWr,
    output logic          id_exMemRead,
    output logic          id_exMemWr,
    output logic          id_exMemToReg,
    output logic          id_exAluSrc,
    output logic [3:0]    id_exAluOp,
    output logic [DW-1:0] id_exA,
    output logic [DW-1:0] id_exB,
    output logic [DW-1:0] id_exImm,
    output logic          pc_write,
    output logic          if_id_write,
    output logic          load_use,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    ctrl_t         ctrl_q, ctrl_d, ctrl_in;
    logic [AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [CW-1:0] stall_q, stall_d, flush_q, flush_d;
    act_e          act;

    hazard_detect #(.AW(AW)) u_hazard (
        .hold_i        (hold),
        .flush_i       (flush),
        .ex_valid_i    (ctrl_q.valid),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rt_i       (rt_q),
        .id_valid_i    (if_idValid),
        .id_rs_i       (if_idRs),
        .id_rt_i       (if_idRt),
        .load_use_o    (load_use),
        .pc_write_o    (pc_write),
        .if_id_write_o (if_id_write),
        .act_o         (act)
    );

    always_comb begin
        ctrl_in = gate_ctrl('{if_idValid, if_idRegWr, if_idMemRead, if_idMemWr,
                              if_idMemToReg, if_idAluSrc, if_idAluOp});
        ctrl_d  = ctrl_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        if (act == ACT_LOAD) begin
            ctrl_d = ctrl_in;
            rs_d   = if_idRs;
            rt_d   = if_idRt;
            rd_d   = if_idRd;
            a_d    = if_idRdA;
            b_d    = if_idRdB;
            imm_d  = if_idImm;
        end else if (act != ACT_HOLD) begin
            ctrl_d = CTRL_BUBBLE;
            rs_d   = '0;
            rt_d   = '0;
            rd_d   = '0;
            a_d    = '0;
            b_d    = '0;
            imm_d  = '0;
        end
        stall_d = (act == ACT_STALL && stall_q != '1) ? stall_q + CW'(1) : stall_q;
        flush_d = (act == ACT_FLUSH && flush_q != '1) ? flush_q + CW'(1) : flush_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= CTRL_BUBBLE;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign id_exValid    = ctrl_q.valid;
    assign id_exRegWr    = ctrl_q.reg_wr;
    assign id_exMemRead  = ctrl_q.mem_read;
    assign id_exMemWr    = ctrl_q.mem_wr;
    assign id_exMemToReg = ctrl_q.mem_to_reg;
    assign id_exAluSrc   = ctrl_q.alu_src;
    assign id_exAluOp    = ctrl_q.alu_op;
    assign id_exRs       = rs_q;
    assign id_exRt       = rt_q;
    assign id_exRd       = rd_q;
    assign id_exA        = a_q;
    assign id_exB        = b_q;
    assign id_exImm      = imm_q;
    assign stall_cnt     = stall_q;
    assign flush_cnt     = flush_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus hold, async-reset and saturation sequences.
module tb_id_ex_stage;

    logic        clk, rst, hold, flush;
    logic        if_idValid, if_idRegWr, if_idMemRead, if_idMemWr, if_idMemToReg, if_idAluSrc;
    logic [3:0]  if_idRs, if_idRt, if_idRd, if_idAluOp;
    logic [15:0] if_idRdA, if_idRdB, if_idImm;
    logic        id_exValid, id_exRegWr, id_exMemRead, id_exMemWr, id_exMemToReg, id_exAluSrc;
    logic [3:0]  id_exRs, id_exRt, id_exRd, id_exAluOp;
    logic [15:0] id_exA, id_exB, id_exImm;
    logic        pc_write, if_id_write, load_use;
    logic [3:0]  stall_cnt, flush_cnt;

    int n_pass = 0;
    int n_total = 0;

    id_ex_stage #(.DW(16), .AW(4), .CW(4)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .if_idValid(if_idValid), .if_idRs(if_idRs), .if_idRt(if_idRt), .if_idRd(if_idRd),
        .if_idRegWr(if_idRegWr), .if_idMemRead(if_idMemRead), .if_idMemWr(if_idMemWr),
        .if_idMemToReg(if_idMemToReg), .if_idAluSrc(if_idAluSrc), .if_idAluOp(if_idAluOp),
        .if_idRdA(if_idRdA), .if_idRdB(if_idRdB), .if_idImm(if_idImm),
        .id_exValid(id_exValid), .id_exRs(id_exRs), .id_exRt(id_exRt), .id_exRd(id_exRd),
        .id_exRegWr(id_exRegWr), .id_exMemRead(id_exMemRead), .id_exMemWr(id_exMemWr),
        .id_exMemToReg(id_exMemToReg), .id_exAluSrc(id_exAluSrc), .id_exAluOp(id_exAluOp),
        .id_exA(id_exA), .id_exB(id_exB), .id_exImm(id_exImm),
        .pc_write(pc_write), .if_id_write(if_id_write), .load_use(load_use),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hold, flush, valid, rs, rt, rd, regwr, memrd, memwr, m2r, alusrc, op, a, b, imm;
        int e_lu, e_pcw, e_valid, e_rs, e_rt, e_rd, e_regwr, e_memrd, e_a, e_b, e_imm, e_stall, e_flush;
    } vec_t;

    vec_t v[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input vec_t x);
        hold = x.hold[0]; flush = x.flush[0]; if_idValid = x.valid[0];
        if_idRs = 4'(x.rs); if_idRt = 4'(x.rt); if_idRd = 4'(x.rd);
        if_idRegWr = x.regwr[0]; if_idMemRead = x.memrd[0]; if_idMemWr = x.memwr[0];
        if_idMemToReg = x.m2r[0]; if_idAluSrc = x.alusrc[0]; if_idAluOp = 4'(x.op);
        if_idRdA = 16'(x.a); if_idRdB = 16'(x.b); if_idImm = 16'(x.imm);
    endtask

    task automatic put(input int h, f, val, rs, rt, rd, rw, mr, a);
        vec_t x;
        x = '{h, f, val, rs, rt, rd, rw, mr, 0, mr, mr, 0, a, 0, 0,
              0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(x);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //      h f v rs rt rd rw mr mw m2r as op a       b      imm    lu pcw vld rs rt rd rw mr a       b      imm  st fl
        v = '{
            '{0,0,1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 'h11,  'h22, 0,     0, 1, 1, 1, 2, 3, 1, 0, 'h11,  'h22, 0,    0, 0},
            '{0,0,1, 1, 5, 0, 1, 1, 0, 1, 1, 0, 'h100, 0,    4,     0, 1, 1, 1, 5, 0, 1, 1, 'h100, 0,    4,    0, 0},
            '{0,0,1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 'h55,  'h11, 0,     1, 0, 0, 0, 0, 0, 0, 0, 0,     0,    0,    1, 0},
            '{0,0,1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 'h55,  'h11, 0,     0, 1, 1, 5, 1, 6, 1, 0, 'h55,  'h11, 0,    1, 0},
            '{0,0,1, 2, 0, 0, 1, 1, 0, 1, 1, 0, 'h22,  0,    0,     0, 1, 1, 2, 0, 0, 1, 1, 'h22,  0,    0,    1, 0},
            '{0,0,1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,     0,    0,     0, 1, 1, 0, 0, 7, 1, 0, 0,     0,    0,    1, 0},
            '{0,0,1, 3, 4, 0, 1, 1, 0, 1, 1, 0, 'h33,  0,    8,     0, 1, 1, 3, 4, 0, 1, 1, 'h33,  0,    8,    1, 0},
            '{0,1,1, 1, 4, 9, 1, 0, 0, 0, 0, 1, 'h11,  'h44, 0,     1, 1, 0, 0, 0, 0, 0, 0, 0,     0,    0,    1, 1},
            '{0,0,0, 2, 3, 8, 1, 0, 1, 0, 0, 2, 'h77,  'h88, 'h12,  0, 1, 0, 2, 3, 8, 0, 0, 'h77,  'h88, 'h12, 1, 1},
            '{0,0,1, 1, 2, 0, 1, 1, 0, 1, 1, 0, 'h11,  0,    0,     0, 1, 1, 1, 2, 0, 1, 1, 'h11,  0,    0,    1, 1},
            '{0,0,0, 2, 2, 4, 1, 0, 0, 0, 0, 0, 'h22,  'h22, 0,     0, 1, 0, 2, 2, 4, 0, 0, 'h22,  'h22, 0,    1, 1},
            '{0,0,1, 1, 2, 0, 1, 1, 0, 1, 1, 0, 'h11,  0,    0,     0, 1, 1, 1, 2, 0, 1, 1, 'h11,  0,    0,    1, 1},
            '{0,0,1, 1, 2, 0, 0, 0, 1, 0, 1, 0, 'h11,  'h99, 0,     1, 0, 0, 0, 0, 0, 0, 0, 0,     0,    0,    2, 1}
        };

        rst = 1'b1;
        put(0, int'($urandom_range(1)), 1, int'($urandom_range(15)), int'($urandom_range(15)),
            int'($urandom_range(15)), 1, 1, int'($urandom_range(16'hffff)));
        step;
        step;
        chk("rst valid", 32'(id_exValid), 0);
        chk("rst rt", 32'(id_exRt), 0);
        chk("rst memrd", 32'(id_exMemRead), 0);
        chk("rst a", 32'(id_exA), 0);
        chk("rst stall", 32'(stall_cnt), 0);
        chk("rst flush", 32'(flush_cnt), 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(v[i]);
            #1;
            chk($sformatf("r%0d load_use", i), 32'(load_use), v[i].e_lu);
            chk($sformatf("r%0d pc_write", i), 32'(pc_write), v[i].e_pcw);
            chk($sformatf("r%0d if_id_write", i), 32'(if_id_write), v[i].e_pcw);
            @(posedge clk);
            #1;
            chk($sformatf("r%0d valid", i), 32'(id_exValid), v[i].e_valid);
            chk($sformatf("r%0d rs", i), 32'(id_exRs), v[i].e_rs);
            chk($sformatf("r%0d rt", i), 32'(id_exRt), v[i].e_rt);
            chk($sformatf("r%0d rd", i), 32'(id_exRd), v[i].e_rd);
            chk($sformatf("r%0d regwr", i), 32'(id_exRegWr), v[i].e_regwr);
            chk($sformatf("r%0d memrd", i), 32'(id_exMemRead), v[i].e_memrd);
            chk($sformatf("r%0d memwr", i), 32'(id_exMemWr), v[i].e_valid != 0 ? v[i].memwr : 0);
            chk($sformatf("r%0d m2r", i), 32'(id_exMemToReg), v[i].e_valid != 0 ? v[i].m2r : 0);
            chk($sformatf("r%0d alusrc", i), 32'(id_exAluSrc), v[i].e_valid != 0 ? v[i].alusrc : 0);
            chk($sformatf("r%0d aluop", i), 32'(id_exAluOp), v[i].e_valid != 0 ? v[i].op : 0);
            chk($sformatf("r%0d a", i), 32'(id_exA), v[i].e_a);
            chk($sformatf("r%0d b", i), 32'(id_exB), v[i].e_b);
            chk($sformatf("r%0d imm", i), 32'(id_exImm), v[i].e_imm);
            chk($sformatf("r%0d stall_cnt", i), 32'(stall_cnt), v[i].e_stall);
            chk($sformatf("r%0d flush_cnt", i), 32'(flush_cnt), v[i].e_flush);
        end

        // hold: load add r10,r1,r3, then freeze three cycles under changing inputs
        put(0, 0, 1, 1, 3, 10, 1, 0, 'h13);
        step;
        for (int k = 0; k < 3; k++) begin
            put(1, k == 1 ? 1 : 0, 1, k + 4, k + 5, k + 12, 1, 1, 'h500 + k);
            #1;
            chk($sformatf("hold%0d pc_write", k), 32'(pc_write), 0);
            chk($sformatf("hold%0d if_id_write", k), 32'(if_id_write), 0);
            step;
            chk($sformatf("hold%0d rd", k), 32'(id_exRd), 10);
            chk($sformatf("hold%0d a", k), 32'(id_exA), 'h13);
            chk($sformatf("hold%0d memrd", k), 32'(id_exMemRead), 0);
            chk($sformatf("hold%0d stall", k), 32'(stall_cnt), 2);
            chk($sformatf("hold%0d flush", k), 32'(flush_cnt), 1);
        end
        put(0, 0, 1, 2, 4, 11, 1, 0, 'h24);
        step;
        chk("unhold rd", 32'(id_exRd), 11);
        chk("unhold a", 32'(id_exA), 'h24);

        // asynchronous reset in the middle of a load-use stall
        put(0, 0, 1, 1, 5, 0, 1, 1, 'h100);
        step;
        put(0, 0, 1, 5, 1, 6, 1, 0, 'h55);
        #1;
        chk("mid load_use", 32'(load_use), 1);
        chk("mid pc_write", 32'(pc_write), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst valid", 32'(id_exValid), 0);
        chk("arst rt", 32'(id_exRt), 0);
        chk("arst memrd", 32'(id_exMemRead), 0);
        chk("arst load_use", 32'(load_use), 0);
        chk("arst pc_write", 32'(pc_write), 1);
        chk("arst if_id_write", 32'(if_id_write), 1);
        chk("arst stall", 32'(stall_cnt), 0);
        chk("arst flush", 32'(flush_cnt), 0);
        step;
        rst = 1'b0;

        // stall counter saturation at 15 with 18 load-use events
        for (int k = 0; k < 18; k++) begin
            put(0, 0, 1, 1, 5, 0, 1, 1, 'h100);
            step;
            put(0, 0, 1, 5, 1, 6, 1, 0, 'h55);
            step;
            if (k == 0) chk("sat stall first", 32'(stall_cnt), 1);
            if (k == 14) chk("sat stall reach", 32'(stall_cnt), 15);
        end
        chk("sat stall hold", 32'(stall_cnt), 15);
        chk("sat bubble rd", 32'(id_exRd), 0);

        for (int k = 0; k < 17; k++) begin
            put(0, 1, 1, 1, 2, 3, 1, 0, 'h11);
            step;
        end
        chk("sat flush", 32'(flush_cnt), 15);
        chk("sat flush stall", 32'(stall_cnt), 15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
